add_pipe: RTL and testbench
===========================

# add_pipe

Parametrised, pipelined carry-lookahead adder/subtractor for the ALU datapath. It splits a WIDTH-bit operation into GROUP-bit lookahead groups and resolves one group per pipeline stage, with the group carry passed between stages. A valid/ready handshake with full backpressure lets it sit between the operand-fetch register stage and the writeback/flag logic at clock rates a single-cycle wide CLA cannot meet.

## Interface
- WIDTH, 32: operand width; must be a multiple of GROUP.
- GROUP, 8: lookahead group width; pipeline depth N = WIDTH/GROUP.
- clk  in  1  rising-edge clock; one clock domain only.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operands present this cycle.
- in_ready  out  1  block accepts operands this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- sub  in  1  0 = A+B+cin, 1 = A−B (B inverted, carry-in forced 1).
- cin  in  1  carry-in, used only when sub=0.
- out_valid  out  1  result present.
- out_ready  in  1  downstream accepts result.
- s  out  WIDTH  sum/difference.
- cout  out  1  carry out of MSB (for sub: 1 = no borrow).
- ovf  out  1  signed overflow.
- zero  out  1  s == 0.

## Operation
- Transfer on the input side: in_valid & in_ready. Transfer on the output side: out_valid & out_ready.
- Global advance enable: en = !out_valid | out_ready. in_ready = en. All stage registers load only when en=1. Bubbles do not collapse while stalled.
- At acceptance, the block forms b' = sub ? ~b : b and c0 = sub ? 1 : cin.
- Stage k (0..N−1) computes group k with one cla_group:
  - per bit g = a&b', p = a^b';
  - carries by full lookahead within the group from the incoming group carry;
  - sum = p ^ carry.
- Stage k registers:
  - the sum bits of groups 0..k;
  - the unprocessed operand groups k+1..N−1;
  - the group carry-out;
  - the MSB carry-in (for ovf);
  - a valid bit.
- Skew registers carry the upper operand groups forward unchanged.
- Final stage outputs:
  - s = assembled sum;
  - cout = group N−1 carry-out;
  - ovf = carry-into-MSB XOR cout;
  - zero = ~|s.
- All outputs are registered.
- Arithmetic is modulo 2^WIDTH.
- Operands are not sign-extended. ovf is meaningful for two's-complement interpretation only.

## Timing
- Latency N cycles from acceptance to out_valid with out_ready held 1 (N=4 at defaults).
- Throughput is one operation per cycle when unstalled.
- Order is preserved.
- At most N operations are in flight.
- Stall: out_valid=1 & out_ready=0 freezes every stage, and in_ready=0 the same cycle. in_ready is combinational from out_ready and out_valid only. No other combinational input-to-output path exists.
- While stalled, s/cout/ovf/zero stay stable.
- Simultaneous output drain and input accept in one cycle is legal and required for full throughput.
- in_valid=0 while en=1 inserts a bubble (valid bit 0). Bubbles never appear at out_valid.
- Reset, including mid-operation: all valid bits clear next edge and in-flight operations are discarded. Outputs reset to out_valid=0, s=0, cout=0, ovf=0, zero=0. in_ready=1 in the first cycle after reset.
- Datapath registers may be left unreset except the output registers.

## Structure
- Shared ALU package holds:
  - the default WIDTH/GROUP constants;
  - an op-mode enum (ADD, SUB) for ALU decode mapping onto sub;
  - an elaboration-time check that WIDTH % GROUP == 0.
- One sub-module, cla_group: combinational GROUP-bit lookahead adder with ports a, b, ci, s, co, c_msb (carry into the top bit). It is instantiated N times via generate.
- Pipeline control (valid bits, en) lives in add_pipe. No separate controller module.

## Test plan
All scenarios use WIDTH=32 and GROUP=8.
- Basic add: a=0x0000_00FF, b=0x0000_0001, sub=0, cin=0, out_ready=1 → after 4 cycles s=0x0000_0100, cout=0, ovf=0, zero=0.
- Full carry ripple across groups: a=0xFFFF_FFFF, b=0, cin=1 → s=0, cout=1, zero=1, ovf=0.
- Subtract/overflow: a=0x8000_0000, b=1, sub=1 → s=0x7FFF_FFFF, cout=1, ovf=1. Separately, a=5, b=7, sub=1 → s=0xFFFF_FFFE, cout=0.
- Back-to-back with backpressure: 6 consecutive ops; out_ready=0 for 3 cycles once the first result is valid → in_ready=0 during the stall, s held constant, all 6 results emerge in order, none lost or duplicated.
- Reset mid-stream: rst=1 for one cycle with 3 ops in flight → next cycle out_valid=0, s=0, in_ready=1, and no stale result is ever emitted.
- Random sweep: 10k random a/b/sub/cin with random out_ready → every result matches the reference model (s, cout, ovf, zero) in order.

Source files
------------

// File: rtl/add_pipe_pkg.sv
// Shared ALU definitions for the pipelined adder/subtractor: default geometry,
// ALU op decode and the elaboration-time geometry check.
package add_pipe_pkg;

    localparam int unsigned DEF_WIDTH = 32;
    localparam int unsigned DEF_GROUP = 8;

    // ALU decode maps onto the adder's sub input.
    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_mode_e;

    // True when WIDTH splits into a whole number of non-empty lookahead groups.
    function automatic bit geometry_ok(input int unsigned width, input int unsigned group);
        return (group != 0) && (width >= group) && ((width % group) == 0);
    endfunction

    function automatic logic op_to_sub(input op_mode_e op);
        return (op == OP_SUB);
    endfunction

endpackage

// File: rtl/add_pipe_cla_group.sv
// Combinational GROUP-bit carry-lookahead adder slice. Every carry is formed
// directly from the generate/propagate terms and the group carry-in.
module cla_group #(
    parameter int unsigned GROUP = 8
) (
    input  logic [GROUP-1:0] a,
    input  logic [GROUP-1:0] b,
    input  logic             ci,
    output logic [GROUP-1:0] s,
    output logic             co,
    output logic             c_msb
);

    logic [GROUP-1:0] g;
    logic [GROUP-1:0] p;
    logic [GROUP:0]   gen_in;
    logic [GROUP:0]   c;

    assign g      = a & b;
    assign p      = a ^ b;
    // Carry-in sits below the generate terms so it is treated as a "g[-1]".
    assign gen_in = {g, ci};

    // Full lookahead: c[i] = OR over j<=i of gen_in[j] & p[j..i-1].
    always_comb begin
        logic term;
        term = 1'b0;
        c    = '0;
        for (int unsigned i = 0; i <= GROUP; i++) begin
            for (int unsigned j = 0; j <= i; j++) begin
                term = gen_in[j];
                for (int unsigned k = j; k < i; k++) begin
                    term = term & p[k];
                end
                c[i] = c[i] | term;
            end
        end
    end

    assign s     = p ^ c[GROUP-1:0];
    assign co    = c[GROUP];
    assign c_msb = c[GROUP-1];

endmodule

// File: rtl/add_pipe.sv
// Pipelined carry-lookahead adder/subtractor. One GROUP-bit lookahead slice is
// resolved per stage; upper operand groups are skewed forward unchanged and the
// group carry is passed stage to stage. Whole-pipeline valid/ready backpressure.
module add_pipe
    import add_pipe_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned GROUP = DEF_GROUP
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int unsigned N = WIDTH / GROUP;

    if (!geometry_ok(WIDTH, GROUP)) begin : g_geometry_check
        $error("add_pipe: WIDTH (%0d) must be a non-zero multiple of GROUP (%0d)", WIDTH, GROUP);
    end

    logic             en;
    logic [WIDTH-1:0] b_eff;
    logic             c0;
    logic [N-1:0]     vld_q;
    logic [N-1:0]     vld_d;

    // The pipeline moves as one; a held output freezes every stage, bubbles included.
    always_comb begin
        en = !out_valid || out_ready;
    end

    assign in_ready  = en;
    assign out_valid = vld_q[N-1];

    // Operand conditioning at acceptance: subtraction is A + ~B + 1.
    always_comb begin
        b_eff = sub ? ~b : b;
        c0    = sub ? 1'b1 : cin;
    end

    // Valid bits shift with the data; an idle input cycle enters as a bubble.
    always_comb begin
        vld_d    = vld_q;
        vld_d[0] = in_valid;
        for (int unsigned i = 1; i < N; i++) begin
            vld_d[i] = vld_q[i-1];
        end
    end

    // Valid register: only state that must be reset to discard in-flight work.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
        end else if (en) begin
            vld_q <= vld_d;
        end
    end

    for (genvar k = 0; k < N; k++) begin : g_stage
        localparam int unsigned LO = k * GROUP;
        localparam int unsigned HI = LO + GROUP;

        logic [WIDTH-LO-1:0] a_in;
        logic [WIDTH-LO-1:0] b_in;
        logic                ci_in;
        logic [HI-1:0]       sum_d;
        logic [GROUP-1:0]    grp_s;
        logic                grp_co;
        logic                grp_cmsb;

        // Stage inputs: operands/carry straight from the ports for stage 0,
        // otherwise the skewed groups and carry registered by the previous stage.
        if (k == 0) begin : g_src
            assign a_in  = a;
            assign b_in  = b_eff;
            assign ci_in = c0;
            assign sum_d = grp_s;
        end else begin : g_src
            assign a_in  = g_stage[k-1].g_mid.a_q;
            assign b_in  = g_stage[k-1].g_mid.b_q;
            assign ci_in = g_stage[k-1].g_mid.co_q;
            assign sum_d = {grp_s, g_stage[k-1].g_mid.sum_q};
        end

        cla_group #(
            .GROUP (GROUP)
        ) u_cla (
            .a     (a_in[GROUP-1:0]),
            .b     (b_in[GROUP-1:0]),
            .ci    (ci_in),
            .s     (grp_s),
            .co    (grp_co),
            .c_msb (grp_cmsb)
        );

        if (k < N-1) begin : g_mid
            logic [HI-1:0]       sum_q;
            logic [WIDTH-HI-1:0] a_q;
            logic [WIDTH-HI-1:0] b_q;
            logic                co_q;
            // Carry into a group's top bit only matters for the MSB group.
            logic                unused_cmsb;
            assign unused_cmsb = grp_cmsb;

            // Intermediate stage register: resolved low sum plus skewed operands.
            always_ff @(posedge clk) begin
                if (en) begin
                    sum_q <= sum_d;
                    a_q   <= a_in[WIDTH-LO-1:GROUP];
                    b_q   <= b_in[WIDTH-LO-1:GROUP];
                    co_q  <= grp_co;
                end
            end
        end else begin : g_last
            logic [WIDTH-1:0] s_q;
            logic             cout_q;
            logic             ovf_q;
            logic             zero_q;

            // Output register: final sum and flags, reset to all-zero.
            always_ff @(posedge clk) begin
                if (rst) begin
                    s_q    <= '0;
                    cout_q <= 1'b0;
                    ovf_q  <= 1'b0;
                    zero_q <= 1'b0;
                end else if (en) begin
                    s_q    <= sum_d;
                    cout_q <= grp_co;
                    ovf_q  <= grp_cmsb ^ grp_co;
                    zero_q <= ~|sum_d;
                end
            end

            assign s    = s_q;
            assign cout = cout_q;
            assign ovf  = ovf_q;
            assign zero = zero_q;
        end
    end

endmodule

// File: tb/tb_add_pipe.sv
// Self-checking bench for add_pipe (WIDTH=32, GROUP=8): directed vector table,
// backpressure and mid-stream reset sequences, and a randomized sweep scored
// against an arithmetic reference model.
module tb_add_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic        cin;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] s;
    logic        cout;
    logic        ovf;
    logic        zero;

    int checks = 0;
    int errors = 0;
    int n_out  = 0;

    typedef struct {
        logic [31:0] s;
        logic        cout;
        logic        ovf;
        logic        zero;
    } res_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sub;
        logic        cin;
        logic [31:0] s;
        logic        cout;
        logic        ovf;
        logic        zero;
    } vec_t;

    res_t expq[$];

    add_pipe #(
        .WIDTH (32),
        .GROUP (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .cout      (cout),
        .ovf       (ovf),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on unsigned and signed interpretations.
    function automatic res_t model(input logic [31:0] x, input logic [31:0] y,
                                   input logic is_sub, input logic c_in);
        res_t        r;
        logic [63:0] ux;
        logic [63:0] uy;
        logic [63:0] tot;
        longint      sx;
        longint      sy;
        longint      sr;
        ux = {32'd0, x};
        uy = {32'd0, y};
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        if (is_sub) begin
            r.s    = x - y;
            r.cout = (ux >= uy);
            sr     = sx - sy;
        end else begin
            tot    = ux + uy + (c_in ? 64'd1 : 64'd0);
            r.s    = tot[31:0];
            r.cout = (tot >= 64'h1_0000_0000);
            sr     = sx + sy + (c_in ? 64'sd1 : 64'sd0);
        end
        r.ovf  = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
        r.zero = (r.s == 32'd0);
        return r;
    endfunction

    function automatic logic [31:0] rand_word();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // Scoreboard: record accepted ops, compare each delivered result in order.
    always @(negedge clk) begin : mon
        res_t e;
        if (rst) begin
            expq.delete();
        end else begin
            if (out_valid && out_ready) begin
                n_out++;
                if (expq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected: got result s=0x%08h, expected no output", s);
                end else begin
                    e = expq.pop_front();
                    chk("sb_s",    64'(s),    64'(e.s));
                    chk("sb_cout", 64'(cout), 64'(e.cout));
                    chk("sb_ovf",  64'(ovf),  64'(e.ovf));
                    chk("sb_zero", 64'(zero), 64'(e.zero));
                end
            end
            if (in_valid && in_ready) begin
                expq.push_back(model(a, b, sub, cin));
            end
        end
    end

    initial begin : main
        vec_t vt[10];
        int   lat;
        int   issued;
        int   start;
        int   stall_left;
        bit   pend;
        bit   stall_done;

        vt[0] = '{32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0, 1'b0};
        vt[1] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
        vt[2] = '{32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0};
        vt[3] = '{32'h0000_0005, 32'h0000_0007, 1'b1, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0};
        vt[4] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0};
        vt[5] = '{32'h1234_5678, 32'h1234_5678, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
        vt[6] = '{32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
        vt[7] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b1};
        vt[8] = '{32'h0000_000A, 32'h0000_0003, 1'b1, 1'b1, 32'h0000_0007, 1'b1, 1'b0, 1'b0};
        vt[9] = '{32'h0000_00FF, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0100, 1'b0, 1'b0, 1'b0};

        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; sub = 1'b0; cin = 1'b0; out_ready = 1'b1;

        // Reset state
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_s",         64'(s),         64'd0);
        chk("rst_cout",      64'(cout),      64'd0);
        chk("rst_ovf",       64'(ovf),       64'd0);
        chk("rst_zero",      64'(zero),      64'd0);
        chk("rst_in_ready",  64'(in_ready),  64'd1);
        @(posedge clk); #1 rst = 1'b0;

        // Directed vectors, one at a time, with latency measurement
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            a = vt[i].a; b = vt[i].b; sub = vt[i].sub; cin = vt[i].cin;
            in_valid = 1'b1; out_ready = 1'b1;
            @(negedge clk);
            chk($sformatf("vec%0d_accept", i), 64'(in_ready), 64'd1);
            @(posedge clk); #1 in_valid = 1'b0;
            lat = 1;
            @(negedge clk);
            while (!out_valid && lat < 20) begin
                @(negedge clk);
                lat++;
            end
            chk($sformatf("vec%0d_latency", i), 64'(lat),  64'd4);
            chk($sformatf("vec%0d_s", i),       64'(s),    64'(vt[i].s));
            chk($sformatf("vec%0d_cout", i),    64'(cout), 64'(vt[i].cout));
            chk($sformatf("vec%0d_ovf", i),     64'(ovf),  64'(vt[i].ovf));
            chk($sformatf("vec%0d_zero", i),    64'(zero), 64'(vt[i].zero));
        end
        @(posedge clk); #1;

        // Back-to-back ops with a 3-cycle output stall after the first result
        issued = 0; start = n_out; stall_left = 0; pend = 1'b0; stall_done = 1'b0;
        for (int cyc = 0; cyc < 100 && (n_out - start) < 6; cyc++) begin
            @(posedge clk); #1;
            if (!pend && issued < 6) begin
                a = rand_word(); b = rand_word(); sub = 1'($urandom_range(0, 1)); cin = 1'($urandom_range(0, 1));
                pend = 1'b1;
                issued++;
            end
            in_valid  = pend;
            out_ready = (stall_left > 0) ? 1'b0 : 1'b1;
            @(negedge clk);
            if (in_valid && in_ready) pend = 1'b0;
            if (!out_ready) begin
                chk("bp_in_ready",  64'(in_ready),  64'd0);
                chk("bp_out_valid", 64'(out_valid), 64'd1);
                if (expq.size() > 0) begin
                    chk("bp_s_held", 64'(s), 64'(expq[0].s));
                end else begin
                    chk("bp_pending_result", 64'(expq.size()), 64'd1);
                end
                stall_left--;
                if (stall_left == 0) stall_done = 1'b1;
            end else if (!stall_done && stall_left == 0 && out_valid) begin
                stall_left = 3;
            end
        end
        @(posedge clk); #1 in_valid = 1'b0; out_ready = 1'b1;
        chk("bp_count",       64'(n_out - start), 64'd6);
        chk("bp_queue_empty", 64'(expq.size()),   64'd0);
        chk("bp_stall_seen",  64'(stall_done),    64'd1);

        // Reset with three operations in flight
        for (int i = 0; i < 3; i++) begin
            if (i > 0) begin
                @(posedge clk); #1;
            end
            a = rand_word(); b = rand_word(); sub = 1'($urandom_range(0, 1)); cin = 1'($urandom_range(0, 1));
            in_valid = 1'b1; out_ready = 1'b1;
            @(negedge clk);
            chk("mr_accept", 64'(in_ready), 64'd1);
        end
        @(posedge clk); #1 in_valid = 1'b0; rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("mr_out_valid", 64'(out_valid), 64'd0);
        chk("mr_s",         64'(s),         64'd0);
        chk("mr_in_ready",  64'(in_ready),  64'd1);
        chk("mr_flags",     64'({cout, ovf, zero}), 64'd0);
        start = n_out;
        repeat (10) @(negedge clk);
        chk("mr_no_stale", 64'(n_out - start), 64'd0);

        // Random sweep with random input gaps and random backpressure
        issued = 0; start = n_out; pend = 1'b0;
        for (int cyc = 0; cyc < 60000 && (n_out - start) < 10000; cyc++) begin
            @(posedge clk); #1;
            if (!pend && issued < 10000 && $urandom_range(0, 3) != 0) begin
                a = rand_word(); b = rand_word(); sub = 1'($urandom_range(0, 1)); cin = 1'($urandom_range(0, 1));
                pend = 1'b1;
                issued++;
            end
            in_valid  = pend;
            out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (in_valid && in_ready) pend = 1'b0;
        end
        @(posedge clk); #1 in_valid = 1'b0; out_ready = 1'b1;
        chk("rand_count",       64'(n_out - start), 64'd10000);
        chk("rand_queue_empty", 64'(expq.size()),   64'd0);

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
